// File: rtl/cnn_pkg.sv
// Shared CNN constants: pixel width, per-layer feature-map sizes and small helpers
// used by the pooling stages.
package cnn_pkg;

    localparam int DATA_W   = 8;
    localparam int L1_MAP_W = 28;
    localparam int L1_MAP_H = 28;
    localparam int L2_MAP_W = 10;
    localparam int L2_MAP_H = 10;

    function automatic int pooled_dim(input int n);
        return n / 2;
    endfunction

    // Index width that never collapses to zero bits for degenerate 1-entry ranges.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] max_s(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/max_pool_2x2_stride2_max4_cmp.sv
// Combinational 4-input maximum as a two-level compare tree; shared by the
// layer-1 and layer-2 pooling stages.
module max4_cmp
    import cnn_pkg::*;
#(
    parameter int DATA_W      = cnn_pkg::DATA_W,
    parameter bit SIGNED_DATA = 1'b0
) (
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    output logic [DATA_W-1:0] max_out
);

    function automatic logic [DATA_W-1:0] pick(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        if (SIGNED_DATA) return ($signed(a) > $signed(b)) ? a : b;
        else             return (a > b) ? a : b;
    endfunction

    logic [DATA_W-1:0] max_top;
    logic [DATA_W-1:0] max_bot;

    always_comb begin
        max_top = pick(in1, in2);
        max_bot = pick(in3, in4);
        max_out = pick(max_top, max_bot);
    end

endmodule

// File: rtl/max_pool_2x2_stride2.sv
// Streaming 2x2 / stride-2 max pooling: tracks pixel position, samples the
// upstream window taps one cycle after en and registers one byte per window.
module max_pool_2x2_stride2
    import cnn_pkg::*;
#(
    parameter int DATA_W      = cnn_pkg::DATA_W,
    parameter int MAP_W       = cnn_pkg::L1_MAP_W,
    parameter int MAP_H       = cnn_pkg::L1_MAP_H,
    parameter bit SIGNED_DATA = 1'b0,
    localparam int OROW_W     = idx_w(pooled_dim(MAP_H)),
    localparam int OCOL_W     = idx_w(pooled_dim(MAP_W))
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clear,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [OROW_W-1:0] out_row,
    output logic [OCOL_W-1:0] out_col,
    output logic              frame_done
);

    localparam int COL_W = idx_w(MAP_W);
    localparam int ROW_W = idx_w(MAP_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAP_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAP_H - 1);
    // Odd sizes drop the trailing column/row, so the last window ends one earlier.
    localparam logic [COL_W-1:0] WIN_COL_LAST = COL_W'((MAP_W / 2) * 2 - 1);
    localparam logic [ROW_W-1:0] WIN_ROW_LAST = ROW_W'((MAP_H / 2) * 2 - 1);

    logic [COL_W-1:0]  col_cnt_q, col_cnt_d, col_base;
    logic [ROW_W-1:0]  row_cnt_q, row_cnt_d, row_base;
    logic [COL_W-1:0]  pos_col_q, pos_col_d;
    logic [ROW_W-1:0]  pos_row_q, pos_row_d;
    logic              en_d_q, en_d_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [OROW_W-1:0] out_row_q, out_row_d;
    logic [OCOL_W-1:0] out_col_q, out_col_d;
    logic              frame_done_q, frame_done_d;
    logic [DATA_W-1:0] win_max;
    logic              win_done;

    max4_cmp #(
        .DATA_W     (DATA_W),
        .SIGNED_DATA(SIGNED_DATA)
    ) u_max4 (
        .in1    (in1),
        .in2    (in2),
        .in3    (in3),
        .in4    (in4),
        .max_out(win_max)
    );

    always_comb begin
        // A clear with en counts the pixel as (0,0) of the new frame.
        col_base  = clear ? '0 : col_cnt_q;
        row_base  = clear ? '0 : row_cnt_q;
        col_cnt_d = col_base;
        row_cnt_d = row_base;
        if (en) begin
            if (col_base == COL_LAST) begin
                col_cnt_d = '0;
                row_cnt_d = (row_base == ROW_LAST) ? '0 : row_base + 1'b1;
            end else begin
                col_cnt_d = col_base + 1'b1;
            end
        end
        en_d_d    = en & ~clear;
        pos_col_d = en ? col_base : pos_col_q;
        pos_row_d = en ? row_base : pos_row_q;

        win_done     = en_d_q & pos_col_q[0] & pos_row_q[0] & ~clear;
        out_data_d   = out_data_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        out_valid_d  = win_done;
        frame_done_d = win_done && (pos_row_q == WIN_ROW_LAST) && (pos_col_q == WIN_COL_LAST);
        if (win_done) begin
            out_data_d = win_max;
            out_row_d  = OROW_W'(pos_row_q >> 1);
            out_col_d  = OCOL_W'(pos_col_q >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            pos_col_q    <= '0;
            pos_row_q    <= '0;
            en_d_q       <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            pos_col_q    <= pos_col_d;
            pos_row_q    <= pos_row_d;
            en_d_q       <= en_d_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2_stride2.sv
// Scoreboard bench: stimulus pushes expected pooled outputs, per-DUT monitors
// pop and compare whenever out_valid is seen.
module tb_max_pool_2x2_stride2;

    typedef struct {
        logic [7:0] d;
        int         r;
        int         c;
        bit         done;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int f_pulses = 0;

    exp_t q_u[$];
    exp_t q_s[$];
    exp_t q_f[$];

    // 2x2 map instances (unsigned / signed) share stimulus
    logic       en_s = 1'b0, clr_s = 1'b0;
    logic [7:0] s1 = 8'h0, s2 = 8'h0, s3 = 8'h0, s4 = 8'h0;
    logic [7:0] u_data, g_data;
    logic       u_valid, g_valid, u_done, g_done;
    logic [0:0] u_row, u_col, g_row, g_col;

    // 28x28 instance
    logic       en_f = 1'b0, clr_f = 1'b0;
    logic [7:0] f1 = 8'h0, f2 = 8'h0, f3 = 8'h0, f4 = 8'h0;
    logic [7:0] f_data;
    logic       f_valid, f_done;
    logic [3:0] f_row, f_col;

    max_pool_2x2_stride2 #(.DATA_W(8), .MAP_W(2), .MAP_H(2), .SIGNED_DATA(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .en(en_s), .clear(clr_s),
        .in1(s1), .in2(s2), .in3(s3), .in4(s4),
        .out_data(u_data), .out_valid(u_valid), .out_row(u_row), .out_col(u_col),
        .frame_done(u_done));

    max_pool_2x2_stride2 #(.DATA_W(8), .MAP_W(2), .MAP_H(2), .SIGNED_DATA(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en_s), .clear(clr_s),
        .in1(s1), .in2(s2), .in3(s3), .in4(s4),
        .out_data(g_data), .out_valid(g_valid), .out_row(g_row), .out_col(g_col),
        .frame_done(g_done));

    max_pool_2x2_stride2 #(.DATA_W(8), .MAP_W(28), .MAP_H(28), .SIGNED_DATA(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .en(en_f), .clear(clr_f),
        .in1(f1), .in2(f2), .in3(f3), .in4(f4),
        .out_data(f_data), .out_valid(f_valid), .out_row(f_row), .out_col(f_col),
        .frame_done(f_done));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: out_valid with no expected window (t=%0t)", name, $time);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        if (u_valid) begin
            if (q_u.size() == 0) unexpected("u_valid");
            else begin
                e = q_u.pop_front();
                chk("u_data", u_data, e.d);
                chk("u_row", u_row, e.r);
                chk("u_col", u_col, e.c);
                chk("u_done", u_done, e.done);
                if (e.cyc >= 0) chk("u_latency", cyc, e.cyc);
            end
        end else if (u_done) chk("u_done_idle", u_done, 0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (g_valid) begin
            if (q_s.size() == 0) unexpected("s_valid");
            else begin
                e = q_s.pop_front();
                chk("s_data", g_data, e.d);
                chk("s_row", g_row, e.r);
                chk("s_col", g_col, e.c);
                chk("s_done", g_done, e.done);
                if (e.cyc >= 0) chk("s_latency", cyc, e.cyc);
            end
        end else if (g_done) chk("s_done_idle", g_done, 0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (f_valid) begin
            f_pulses++;
            if (q_f.size() == 0) unexpected("f_valid");
            else begin
                e = q_f.pop_front();
                chk("f_data", f_data, e.d);
                chk("f_row", f_row, e.r);
                chk("f_col", f_col, e.c);
                chk("f_done", f_done, e.done);
            end
        end else if (f_done) chk("f_done_idle", f_done, 0);
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [7:0] pv(input int r, input int c, input int seed);
        if (r < 0 || c < 0) return 8'h00;
        return 8'((r * 28 + c + seed) % 256);
    endfunction

    function automatic logic [7:0] ref_max(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
        logic [7:0] v[4];
        logic [7:0] m;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        m = 8'h00;
        for (int i = 0; i < 4; i++) if (v[i] > m) m = v[i];
        return m;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Shift one pixel into the 28x28 stage; taps then reflect the upstream buffer.
    task automatic drive_px(input int r, input int c, input int seed, input int gap, input bit clr);
        exp_t e;
        en_f  = 1'b1;
        clr_f = clr;
        @(posedge clk);
        #1;
        en_f  = 1'b0;
        clr_f = 1'b0;
        f1 = pv(r - 1, c - 1, seed);
        f2 = pv(r - 1, c, seed);
        f3 = pv(r, c - 1, seed);
        f4 = pv(r, c, seed);
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            e.d = ref_max(f1, f2, f3, f4);
            e.r = r / 2;
            e.c = c / 2;
            e.done = (r == 27) && (c == 27);
            e.cyc = -1;
            q_f.push_back(e);
        end
        idle(gap);
    endtask

    task automatic drive_pixels(input int npix, input int seed, input int maxgap, input bit clr_first);
        for (int i = 0; i < npix; i++)
            drive_px(i / 28, i % 28, seed, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0,
                     clr_first && (i == 0));
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && (q_f.size() + q_u.size() + q_s.size()) != 0; i++) idle(1);
        chk({name, "_drained"}, q_f.size() + q_u.size() + q_s.size(), 0);
    endtask

    task automatic full_frame(input string name, input int seed, input int maxgap, input bit clr_first);
        f_pulses = 0;
        drive_pixels(784, seed, maxgap, clr_first);
        drain(name);
        chk({name, "_pulses"}, f_pulses, 196);
    endtask

    // Four pixels into the 2x2 stages; taps show the full window after the 4th.
    task automatic small_win(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic [7:0] exp_u, input logic [7:0] exp_s);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                e.r = 0; e.c = 0; e.done = 1'b1; e.cyc = cyc + 2;
                e.d = exp_u; q_u.push_back(e);
                e.d = exp_s; q_s.push_back(e);
            end
            en_s = 1'b1;
            @(posedge clk);
            #1;
            en_s = 1'b0;
        end
        s1 = a; s2 = b; s3 = c; s4 = d;
        idle(3);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #2;
        chk("rst_f_valid", f_valid, 0);
        chk("rst_f_data", f_data, 0);
        chk("rst_f_rowcol", {f_row, f_col}, 0);
        chk("rst_f_done", f_done, 0);
        chk("rst_u_valid", u_valid, 0);
        chk("rst_s_data", g_data, 0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single window and signed/unsigned compare
        small_win(8'd3, 8'd9, 8'd7, 8'd5, 8'd9, 8'd9);
        small_win(8'h80, 8'hFF, 8'h01, 8'h7F, 8'hFF, 8'h7F);
        small_win(8'h80, 8'h81, 8'hFE, 8'h80, 8'hFE, 8'hFE);
        small_win(8'h00, 8'h80, 8'h7F, 8'h01, 8'h80, 8'h7F);
        small_win(8'h11, 8'h22, 8'h44, 8'h33, 8'h44, 8'h44);
        drain("small");

        // full frame, back-to-back en, then same frame with random gaps
        full_frame("frame_cont", 0, 0, 1'b0);
        full_frame("frame_gap", 0, 5, 1'b0);

        // clear right after a completed window: its pending result is dropped
        drive_pixels(30, 0, 0, 1'b0);
        clr_f = 1'b1;
        void'(q_f.pop_back());
        idle(1);
        clr_f = 1'b0;
        idle(3);
        drain("clear_pending");

        // clear together with en at pixel (5,11): that pixel becomes (0,0)
        drive_pixels(5 * 28 + 11, 0, 0, 1'b0);
        idle(3);
        drain("pre_clear");
        full_frame("frame_after_clear", 7, 0, 1'b1);

        // asynchronous reset mid-frame
        drive_pixels(7 * 28 + 5, 3, 0, 1'b0);
        idle(3);
        drain("pre_reset");
        chk("pre_reset_valid_data", (f_data != 0) && (f_row == 4'd3), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", f_valid, 0);
        chk("mid_rst_data", f_data, 0);
        chk("mid_rst_row", f_row, 0);
        chk("mid_rst_col", f_col, 0);
        chk("mid_rst_done", f_done, 0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        full_frame("frame_after_reset", 100, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
